// File: rtl/sm_bsr_driver_if.sv
// rtl/sm_bsr_driver_if.sv - host command/response bundle for the BSR scan driver
interface sm_bsr_driver_if #(
  parameter int WIDTH = 40,
  parameter int LEN_W = 6
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] tx_data;
  logic             mode_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;

  modport master (output start, len, tx_data, mode_req, input busy, done, rx_data);
  modport slave  (input start, len, tx_data, mode_req, output busy, done, rx_data);
endinterface

// File: rtl/sm_bsr_driver.sv
// rtl/sm_bsr_driver.sv - boundary-scan DR chain master: capture, shift, update
module sm_bsr_driver #(
  parameter int WIDTH = 40,
  parameter int LEN_W = 6,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sm_bsr_driver_if.slave   host,
  output logic             s_data_in,
  input  logic             s_data_out,
  output logic             shift_dr,
  output logic             clk_dr,
  output logic             update_dr,
  output logic             mode
);

  localparam int PH_W = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam logic [PH_W-1:0]  PH_HI   = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] tx_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx;
  logic [PH_W-1:0]  ph;
  logic             ph_last;
  logic [LEN_W-1:0] next_idx;

  assign ph_last  = (ph == PH_LAST);
  assign next_idx = bit_idx + 1'b1;

  // ph walks one pulse: DIV low cycles then DIV high cycles; strobes are
  // computed one edge early so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_q         <= '0;
      len_q        <= '0;
      bit_idx      <= '0;
      ph           <= '0;
      host.busy    <= 1'b0;
      host.done    <= 1'b0;
      host.rx_data <= '0;
      s_data_in    <= 1'b0;
      shift_dr     <= 1'b0;
      clk_dr       <= 1'b0;
      update_dr    <= 1'b0;
      mode         <= 1'b0;
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            tx_q         <= host.tx_data;
            len_q        <= (host.len > LEN_MAX) ? LEN_MAX : host.len;
            mode         <= host.mode_req;
            host.rx_data <= '0;
            host.busy    <= 1'b1;
            ph           <= '0;
            state        <= CAPTURE;
          end
        end
        CAPTURE, SHIFT, UPDATE: begin
          if (!ph_last) begin
            ph <= ph + 1'b1;
            if (state == UPDATE) update_dr <= (ph >= PH_HI);
            else                 clk_dr    <= (ph >= PH_HI);
            // last low cycle: the chain end is still stable before clk_dr rises
            if (state == SHIFT && ph == PH_HI) host.rx_data[bit_idx] <= s_data_out;
          end else begin
            ph        <= '0;
            clk_dr    <= 1'b0;
            update_dr <= 1'b0;
            case (state)
              CAPTURE: begin
                if (len_q == '0) begin
                  state <= UPDATE;
                end else begin
                  state     <= SHIFT;
                  shift_dr  <= 1'b1;
                  bit_idx   <= '0;
                  s_data_in <= tx_q[0];
                end
              end
              SHIFT: begin
                if (bit_idx == len_q - 1'b1) begin
                  state    <= UPDATE;
                  shift_dr <= 1'b0;
                end else begin
                  bit_idx   <= next_idx;
                  s_data_in <= tx_q[next_idx];
                end
              end
              default: begin
                host.busy <= 1'b0;
                host.done <= 1'b1;
                state     <= FINISH;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_bsr_driver.sv
// tb/tb_sm_bsr_driver.sv - random + directed scans against a behavioural chain and timing model
module tb_sm_bsr_driver;
  localparam int W  = 40;
  localparam int LW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          start_v[2];
  logic [LW-1:0] len_v[2];
  logic [W-1:0]  tx_v[2];
  logic [W-1:0]  pre_v[2];
  logic          mode_v[2];
  logic          busy_w[2];
  logic          done_w[2];
  logic          mode_w[2];
  logic [W-1:0]  rx_w[2];
  logic [W-1:0]  upd_reg_v[2];
  int            rise_v[2];
  int            urise_v[2];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 2 : 1;
    sm_bsr_driver_if #(.WIDTH(W), .LEN_W(LW)) bif();
    logic sdi, sdo, sh, cdr, upd, md;
    logic [W-1:0] cells;

    assign bif.start    = start_v[g];
    assign bif.len      = len_v[g];
    assign bif.tx_data  = tx_v[g];
    assign bif.mode_req = mode_v[g];
    assign busy_w[g]    = bif.busy;
    assign done_w[g]    = bif.done;
    assign rx_w[g]      = bif.rx_data;
    assign mode_w[g]    = md;

    sm_bsr_driver #(.WIDTH(W), .LEN_W(LW), .DIV(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .host(bif), .s_data_in(sdi), .s_data_out(sdo),
      .shift_dr(sh), .clk_dr(cdr), .update_dr(upd), .mode(md));

    // 40-cell chain: cell 0 feeds the master, s_data_in enters at cell 39
    always @(posedge cdr) cells <= sh ? {sdi, cells[W-1:1]} : pre_v[g];
    assign sdo = cells[0];
    always @(posedge upd) upd_reg_v[g] <= cells;

    function automatic string nm(input string s);
      return $sformatf("%s_i%0d", s, g);
    endfunction

    int m_n = 0, m_l = 0, m_t = 0;
    logic [W-1:0] m_tx, m_rx, m_upd;
    logic m_mode;

    initial begin : model
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          m_n = 0; m_mode = 1'b0; m_rx = '0;
        end else if (m_n == 0) begin
          if (start_v[g]) begin
            m_l = (int'(len_v[g]) > W) ? W : int'(len_v[g]);
            m_t = (m_l + 2) * 2 * D;
            m_tx = tx_v[g];
            m_mode = mode_v[g];
            m_rx = '0;
            for (int k = 0; k < m_l; k++) m_rx[k] = pre_v[g][k];
            for (int i = 0; i < W; i++) begin
              if (i + m_l < W) m_upd[i] = pre_v[g][i + m_l];
              else             m_upd[i] = m_tx[i + m_l - W];
            end
            m_n = 1;
          end
        end else if (m_n == m_t + 1) begin
          m_n = 0;
        end else begin
          m_n++;
        end
      end
    end

    initial begin : cmp
      logic pcdr, pupd;
      int p, ph;
      pcdr = 1'b0; pupd = 1'b0;
      forever begin
        @(negedge clk);
        if (m_n == 1) begin rise_v[g] = 0; urise_v[g] = 0; end
        if (cdr && !pcdr) rise_v[g]++;
        if (upd && !pupd) urise_v[g]++;
        pcdr = cdr; pupd = upd;
        if (!rst_n) begin
          chk(nm("rst_out"), {bif.busy, bif.done, sdi, sh, cdr, upd, md}, 0);
          chk(nm("rst_rx"), bif.rx_data, 0);
        end else if (m_n == 0) begin
          chk(nm("idle_ctl"), {bif.busy, bif.done, sh, cdr, upd}, 0);
          chk(nm("idle_mode"), md, m_mode);
          chk(nm("idle_rx"), bif.rx_data, m_rx);
        end else if (m_n <= m_t) begin
          p  = (m_n - 1) / (2 * D);
          ph = (m_n - 1) % (2 * D);
          chk(nm("busy_ctl"), {bif.busy, bif.done, md}, {1'b1, 1'b0, m_mode});
          if (p == 0) begin
            chk(nm("capture"), {sh, cdr, upd}, {1'b0, ph >= D, 1'b0});
          end else if (p <= m_l) begin
            chk(nm("shift"), {sh, cdr, upd}, {1'b1, ph >= D, 1'b0});
            chk(nm("sdi"), sdi, m_tx[p - 1]);
          end else begin
            chk(nm("update"), {sh, cdr, upd}, {1'b0, 1'b0, ph >= D});
          end
        end else begin
          chk(nm("fin_ctl"), {bif.busy, bif.done, sh, cdr, upd}, 5'b01000);
          chk(nm("fin_rx"), bif.rx_data, m_rx);
          chk(nm("fin_updreg"), upd_reg_v[g], m_upd);
          chk(nm("fin_rises"), rise_v[g], m_l + 1);
          chk(nm("fin_urises"), urise_v[g], 1);
        end
      end
    end
  end

  task automatic run_scan(input int inst, input int ln, input logic [W-1:0] tx, input logic md,
                          input logic [W-1:0] pre, input bit noise, output int bcnt);
    int c;
    len_v[inst] = LW'(ln); tx_v[inst] = tx; mode_v[inst] = md; pre_v[inst] = pre;
    start_v[inst] = 1'b1;
    c = 0;
    do begin step(1); c++; end while (!busy_w[inst] && c < 10);
    chk("accept", busy_w[inst], 1);
    start_v[inst] = 1'b0;
    bcnt = 1; c = 0;
    while (!done_w[inst] && c < 3000) begin
      step(1); c++;
      if (busy_w[inst]) bcnt++;
      if (noise) begin
        start_v[inst] = busy_w[inst] ? 1'($urandom_range(0, 1)) : 1'b0;
        mode_v[inst]  = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", done_w[inst], 1);
    start_v[inst] = 1'b0;
  endtask

  initial begin : stim
    int b, inst, ln, cl, c;
    logic [W-1:0] p3, p4;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; len_v[i] = '0; tx_v[i] = '0; pre_v[i] = '0; mode_v[i] = 1'b0;
    end
    repeat (6) begin
      step(1);
      for (int i = 0; i < 2; i++) begin
        start_v[i] = 1'($urandom_range(0, 1)); len_v[i] = LW'($urandom);
        tx_v[i] = W'({$urandom, $urandom}); mode_v[i] = 1'($urandom_range(0, 1));
      end
    end
    step(1);
    for (int i = 0; i < 2; i++) begin start_v[i] = 1'b0; mode_v[i] = 1'b0; end
    step(1);
    rst_n = 1'b1;
    step(6);

    run_scan(0, 40, 40'h00_0000_0003, 1'b0, 40'hA5_1234_5678, 1'b0, b);
    chk("s1_busy", b, 168);
    chk("s1_rises", rise_v[0], 41);
    chk("s1_urises", urise_v[0], 1);
    chk("s1_rx", rx_w[0], 40'hA5_1234_5678);
    chk("s1_updreg", upd_reg_v[0], 40'h00_0000_0003);

    run_scan(0, 0, W'({$urandom, $urandom}), 1'b0, W'({$urandom, $urandom}), 1'b0, b);
    chk("s2_busy", b, 8);
    chk("s2_rises", {rise_v[0][15:0], urise_v[0][15:0]}, 32'h0001_0001);
    chk("s2_rx", rx_w[0], 0);
    step(3);

    p3 = W'({$urandom, $urandom});
    run_scan(1, 8, 40'h02, 1'b0, p3, 1'b0, b);
    chk("s3_busy", b, 20);
    chk("s3_rises", rise_v[1], 9);
    chk("s3_rx_hi", rx_w[1][39:8], 0);
    chk("s3_rx_lo", rx_w[1][7:0], p3[7:0]);
    chk("s3_updreg", upd_reg_v[1], {8'h02, p3[39:8]});

    p4 = W'({$urandom, $urandom});
    run_scan(0, 63, W'({$urandom, $urandom}), 1'b0, p4, 1'b1, b);
    chk("s4_busy", b, 168);
    chk("s4_rises", rise_v[0], 41);
    chk("s4_rx", rx_w[0], p4);

    run_scan(0, 12, W'({$urandom, $urandom}), 1'b1, W'({$urandom, $urandom}), 1'b1, b);
    chk("s5_mode", mode_w[0], 1);

    for (int n = 0; n < 16; n++) begin
      inst = $urandom_range(0, 1);
      ln = $urandom_range(0, 63);
      run_scan(inst, ln, W'({$urandom, $urandom}), 1'($urandom_range(0, 1)),
               W'({$urandom, $urandom}), 1'b1, b);
      cl = (ln > W) ? W : ln;
      chk("rand_busy", b, (cl + 2) * 2 * ((inst == 0) ? 2 : 1));
      step($urandom_range(0, 3));
    end

    len_v[0] = LW'(40); tx_v[0] = W'({$urandom, $urandom}); mode_v[0] = 1'b1;
    start_v[0] = 1'b1;
    c = 0;
    do begin step(1); c++; end while (!busy_w[0] && c < 10);
    chk("abort_accept", busy_w[0], 1);
    start_v[0] = 1'b0;
    step(30);
    rst_n = 1'b0;
    step(1);
    chk("abort_state", {busy_w[0], done_w[0], mode_w[0]}, 0);
    step(2);
    rst_n = 1'b1;
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
